// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding over a DEPTH-entry write-intent scoreboard.
// Optional feature: define ZERO_REG_EN to make register 0 read as zero and never be written.
module hazard_fwd_unit #(
  parameter int DBITS = 16,
  parameter int RBITS = 3,
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_id_valid,
  input  logic [RBITS-1:0]       i_id_rs1,
  input  logic [RBITS-1:0]       i_id_rs2,
  input  logic                   i_id_use1,
  input  logic                   i_id_use2,
  input  logic                   i_id_wr,
  input  logic [RBITS-1:0]       i_id_wdst,
  input  logic                   i_id_isload,
  input  logic                   i_br_taken,
  input  logic [DBITS-1:0]       i_reg_out1,
  input  logic [DBITS-1:0]       i_reg_out2,
  input  logic [DEPTH*DBITS-1:0] i_stage_val,
  output logic [DBITS-1:0]       o_oper1,
  output logic [DBITS-1:0]       o_oper2,
  output logic                   o_fwd1_hit,
  output logic                   o_fwd2_hit,
  output logic                   o_stall,
  output logic                   o_wb_we,
  output logic [RBITS-1:0]       o_wb_dst,
  output logic [15:0]            o_stall_cnt
);

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_wr;
  logic [DEPTH-1:0] r_ld;
  logic [RBITS-1:0] r_dst [DEPTH];
  logic [15:0]      r_stall_cnt;

  logic             w_m1, w_m2;
  logic             w_k0_1, w_k0_2;
  logic [DBITS-1:0] w_fv1, w_fv2;
  logic             w_z1, w_z2;
  logic             w_dst_ok;
  logic             w_lu1, w_lu2;
  logic             w_stall;

`ifdef ZERO_REG_EN
  assign w_z1     = (i_id_rs1 == '0);
  assign w_z2     = (i_id_rs2 == '0);
  assign w_dst_ok = (i_id_wdst != '0);
`else
  assign w_z1     = 1'b0;
  assign w_z2     = 1'b0;
  assign w_dst_ok = 1'b1;
`endif

  // Scan oldest to youngest so the lowest-index (youngest) match is the one kept.
  always_comb begin
    w_m1   = 1'b0;
    w_m2   = 1'b0;
    w_k0_1 = 1'b0;
    w_k0_2 = 1'b0;
    w_fv1  = '0;
    w_fv2  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_v[k] && r_wr[k] && (r_dst[k] == i_id_rs1) && i_id_use1) begin
        w_m1   = 1'b1;
        w_k0_1 = (k == 0);
        w_fv1  = i_stage_val[k*DBITS +: DBITS];
      end
      if (r_v[k] && r_wr[k] && (r_dst[k] == i_id_rs2) && i_id_use2) begin
        w_m2   = 1'b1;
        w_k0_2 = (k == 0);
        w_fv2  = i_stage_val[k*DBITS +: DBITS];
      end
    end
  end

  // Load data is not available in EX, so a youngest-match load in entry 0 cannot forward.
  assign w_lu1   = w_m1 && w_k0_1 && r_ld[0] && !w_z1;
  assign w_lu2   = w_m2 && w_k0_2 && r_ld[0] && !w_z2;
  assign w_stall = i_id_valid && !i_br_taken && (w_lu1 || w_lu2);

  always_comb begin
    o_oper1    = i_reg_out1;
    o_fwd1_hit = 1'b0;
    if (w_z1) begin
      o_oper1 = '0;
    end else if (w_m1 && !w_lu1) begin
      o_oper1    = w_fv1;
      o_fwd1_hit = 1'b1;
    end
  end

  always_comb begin
    o_oper2    = i_reg_out2;
    o_fwd2_hit = 1'b0;
    if (w_z2) begin
      o_oper2 = '0;
    end else if (w_m2 && !w_lu2) begin
      o_oper2    = w_fv2;
      o_fwd2_hit = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_v         <= '0;
      r_wr        <= '0;
      r_ld        <= '0;
      r_stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_dst[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]   <= r_v[k-1];
        r_wr[k]  <= r_wr[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      r_v[0]   <= i_id_valid && !w_stall && !i_br_taken;
      r_wr[0]  <= i_id_wr && w_dst_ok;
      r_ld[0]  <= i_id_isload;
      r_dst[0] <= i_id_wdst;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign o_stall     = w_stall;
  assign o_wb_we     = r_v[DEPTH-1] && r_wr[DEPTH-1];
  assign o_wb_dst    = r_dst[DEPTH-1];
  assign o_stall_cnt = r_stall_cnt;

endmodule
